// File: rtl/ripadd_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | ripadd_sched : time-multiplexed 4-bit ripple-carry adder with a           |
// |                two-requester round-robin front end and tagged response.  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+

module ripadd_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule

module ripadd_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int C_N  = WIDTH / 4;
  localparam int C_KW = (C_N > 1) ? $clog2(C_N) : 1;
  localparam logic [C_KW-1:0] C_K_LAST = C_KW'(C_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [C_KW-1:0]  r_k;
  logic             r_carry;
  logic             r_last_id;
  logic             r_id;
  logic             r_cout;
  logic             r_rsp_valid;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;

  assign w_idle = (r_state == ST_IDLE);

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_id;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready = rst_n & w_idle & req0_valid & ~w_grant;
  assign req1_ready = rst_n & w_idle & req1_valid &  w_grant;
  assign w_accept   = req0_ready | req1_ready;

  assign w_a_nib = r_a[{r_k, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_k, 2'b00} +: 4];

  ripadd_slice4 u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_last_id   <= 1'b1;
      r_id        <= 1'b0;
      r_cout      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a       <= w_grant ? req1_a   : req0_a;
            r_b       <= w_grant ? req1_b   : req0_b;
            r_carry   <= w_grant ? req1_cin : req0_cin;
            r_id      <= w_grant;
            r_last_id <= w_grant;
            r_k       <= '0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[{r_k, 2'b00} +: 4] <= w_slice_sum;
          r_carry                  <= w_slice_cout;
          if (r_k == C_K_LAST) begin
            r_k         <= '0;
            r_cout      <= w_slice_cout;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_k <= r_k + C_KW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
  assign busy      = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_ripadd_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_ripadd_sched : scoreboard bench for ripadd_sched (WIDTH=16).           |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+

module tb_ripadd_sched;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_cin = 1'b0, req1_cin = 1'b0;
  logic             rsp_valid, rsp_cout, rsp_id, busy;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_sum;

  ripadd_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   busy_cnt = 0;
  int   m_state = 0;   // 0 idle, 1 run, 2 done
  int   m_k = 0;
  logic m_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at the falling edge with inputs applied.
  task automatic cyc();
    logic             e0, e1;
    logic [WIDTH:0]   t;
    exp_t             h;
    #1;
    e0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
    e1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
    if (m_state == 2) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=response expected=no_response");
      end else begin
        h = sb[0];
        chk("rsp_sum", 32'(rsp_sum), 32'(h.sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(h.cout));
        chk("rsp_id", 32'(rsp_id), 32'(h.id));
      end
    end
    if (busy) busy_cnt++;
    if (e0) t = {1'b0, req0_a} + {1'b0, req0_b} + 17'(req0_cin);
    else    t = {1'b0, req1_a} + {1'b0, req1_b} + 17'(req1_cin);
    @(posedge clk);
    if (m_state == 0 && (e0 || e1)) begin
      h.sum  = t[WIDTH-1:0];
      h.cout = t[WIDTH];
      h.id   = e1;
      sb.push_back(h);
      m_last  = e1;
      m_state = 1;
      m_k     = 0;
    end else if (m_state == 1) begin
      if (m_k == N - 1) m_state = 2;
      else m_k++;
    end else if (m_state == 2 && rsp_ready) begin
      void'(sb.pop_front());
      pops++;
      m_state = 0;
    end
    #1;
    if (e0) req0_valid = 1'b0;
    if (e1) req1_valid = 1'b0;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; both valids raised to show readys are masked.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", 32'(busy), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_state = 0;
    m_k     = 0;
    m_last  = 1'b1;
    sb.delete();
  endtask

  task automatic load0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
  endtask

  task automatic load1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
  endtask

  initial begin
    int base;
    @(negedge clk);
    do_reset();

    // Basic add and busy duration.
    rsp_ready = 1'b1;
    busy_cnt  = 0;
    load0(16'h1234, 16'h4321, 1'b0);
    repeat (8) cyc();
    chk("busy_cycles", 32'(busy_cnt), 32'd5);

    // Carry propagation through every nibble.
    load1(16'hFFFF, 16'h0001, 1'b0);
    repeat (8) cyc();
    load1(16'hFFFF, 16'h0000, 1'b1);
    repeat (8) cyc();

    // Arbitration from reset, then a third tie.
    do_reset();
    load0(16'h0001, 16'h0001, 1'b0);
    load1(16'h8000, 16'h8000, 1'b0);
    repeat (14) cyc();
    load0(16'h0102, 16'h0304, 1'b0);
    load1(16'h7FFF, 16'h0001, 1'b1);
    repeat (14) cyc();

    // Back-pressure in DONE with a competing request pending.
    rsp_ready = 1'b0;
    load0(16'hBEEF, 16'h1111, 1'b1);
    cyc();
    load1(16'h2222, 16'h3333, 1'b0);
    repeat (4) cyc();
    repeat (3) cyc();
    rsp_ready = 1'b1;
    repeat (9) cyc();

    // Reset in the middle of an operation.
    load0(16'hAAAA, 16'h5555, 1'b0);
    for (int i = 0; i < 10 && !(m_state == 1 && m_k == 2); i++) cyc();
    do_reset();
    load0(16'h0F0F, 16'h00F1, 1'b1);
    repeat (8) cyc();

    // Random traffic with random back-pressure.
    base = pops;
    for (int c = 0; c < 60000 && (pops - base) < 1000; c++) begin
      if (!req0_valid && ($urandom_range(0, 1) == 1))
        load0(16'($urandom), 16'($urandom), 1'($urandom));
      if (!req1_valid && ($urandom_range(0, 1) == 1))
        load1(16'($urandom), 16'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    chk("rand_ops", 32'(pops - base), 32'd1000);

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (2 * (N + 2) + 4) cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ripadd_sched.md
# ripadd_sched

Sequencer and arbiter for the team's 4-bit ripple-carry slice. The block owns one 4-bit ripple-carry adder (full-adder chain, `cout = a&b | cin&(a^b)`). It time-multiplexes that adder across the nibbles of a WIDTH-bit addition, one nibble per cycle, and chains the carry through a register. Two requesters share the block through round-robin arbitration. Results return on a single valid/ready response channel tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  block accepts requester 0 this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- rsp_cout  output  1  carry out of bit WIDTH-1
- rsp_id  output  1  requester that issued this result
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant: if only one reqX_valid is high, grant X. If both are high, grant the requester ≠ last_id. last_id resets to 1, so req0 wins the first tie.
  - reqX_ready = (state==IDLE) & grant==X, combinational. It is never high for both requesters.
  - On valid&ready, the block captures a, b, cin and id, sets last_id=id, k=0, carry=cin, and goes to RUN.
- RUN: each cycle, the slice adds a[4k+3:4k] + b[4k+3:4k] + carry.
  - The nibble result is written into sum[4k+3:4k], and carry ← slice cout.
  - k increments. On k==N-1, the state goes to DONE.
  - Request inputs are ignored and both readys stay 0.
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are registered and stable until the handshake.
  - On rsp_valid&rsp_ready, go to IDLE and drop rsp_valid.
  - The block does not accept a new request in the same cycle as the response handshake.
- Arithmetic: the result equals the full WIDTH-bit unsigned sum. rsp_cout is the final slice carry.
- The sum register is not cleared between operations. Every nibble is overwritten before DONE.

## Timing
- Reset (rst_n=0, any time, including mid-RUN or in DONE):
  - State goes to IDLE immediately; any in-flight operation is discarded.
  - k=0, carry=0, last_id=1.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0.
  - reqX_ready follows the IDLE grant logic. While rst_n=0, both readys are forced to 0.
- Accept edge E0 → RUN during E0..E(N-1) edges → rsp_valid high from the cycle after edge E(N). That is a latency of N cycles from the accept edge (N=4 for WIDTH=16).
- Throughput: at best one operation per N+2 cycles, with rsp_ready held high.
- Back-pressure: with rsp_ready=0, DONE holds indefinitely. Outputs do not change.
- A request whose valid drops before it is granted is never captured. Requesters must not rely on it being accepted.
- Simultaneous valids in IDLE: exactly one is granted. The other wins the next IDLE cycle if it is still valid.

## Test plan
- WIDTH=16, req0: a=0x1234, b=0x4321, cin=0 → after 4 cycles rsp_sum=0x5555, rsp_cout=0, rsp_id=0; busy high for 5 cycles total.
- Carry chain: req1: a=0xFFFF, b=0x0001, cin=0 → rsp_sum=0x0000, rsp_cout=1, rsp_id=1. Also a=0xFFFF, b=0x0000, cin=1 → 0x0000, cout=1.
- Arbitration: both valid from reset, req0: 0x0001+0x0001, req1: 0x8000+0x8000 → first response id=0, sum=0x0002, cout=0. Second response id=1, sum=0x0000, cout=1. A third tie grants req0.
- Back-pressure: hold rsp_ready=0 for 3 cycles in DONE → rsp_valid, sum, cout and id are stable; req0_ready and req1_ready stay 0; IDLE is reached 1 cycle after rsp_ready=1.
- Reset mid-RUN: assert rst_n=0 at k=2 of 0xAAAA+0x5555 → immediate IDLE, rsp_valid=0, rsp_sum=0. After release, 0x0F0F+0x00F1 cin=1 → 0x1001, cout=0.
- Random: 1000 operations, both requesters with random valid, rsp_ready random → every result matches a+b+cin, ids alternate under contention, and no request is lost or duplicated.
